// File: rtl/caches_pkg.sv
// caches_pkg: shared types and constants for the cache/memory subsystem.
//   word_t      : 32-bit data/address word
//   arb_state_t : mem_arbiter grant state
//   BAD_DATA    : load value returned when the RAM watchdog fires
package caches_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } arb_state_t;

  localparam word_t BAD_DATA = 32'hBAD1_BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache and dcache miss traffic onto one RAM port.
// Dcache bursts of BS words are held under a single grant; a starvation
// counter forces an icache grant after STARVE_MAX consecutive dcache grants
// while iREN is pending; a watchdog completes a hung access with BAD_DATA
// and raises the sticky err flag.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   iREN, iaddr              icache read request / address
//   iwait, iload             icache stall / read data
//   dREN, dWEN, daddr, dstore dcache read/write request, address, write data
//   dwait, dload             dcache stall / read data
//   ram_ren, ram_wen         RAM strobes
//   ram_addr, ram_wdata      RAM address / write data
//   ram_rdata, ram_ready     RAM read data / per-word completion
//   err                      sticky watchdog flag
module mem_arbiter
  import caches_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BS         = 2,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              err
);

  localparam int IS_W = $clog2(STARVE_MAX + 1);
  localparam int WC_W = $clog2(BS + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [IS_W-1:0] IS_MAX  = IS_W'(STARVE_MAX);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(BS - 1);
  localparam logic [WD_W-1:0] WD_TOP  = WD_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] BAD   = DATA_W'(BAD_DATA);

  arb_state_t      state;
  logic [IS_W-1:0] istarve;
  logic [WC_W-1:0] wcnt;
  logic [WD_W-1:0] wdog;

  logic dreq;
  logic d_is_wr;
  logic wd_fire;

  assign dreq    = dREN | dWEN;
  assign d_is_wr = dWEN;
  assign wd_fire = (wdog == WD_TOP);

  // Outputs are combinational from the registered state so that completion
  // (wait low) lands in the same cycle as ram_ready. A requester dropping its
  // request masks the strobes immediately and suppresses any acknowledge.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    unique case (state)
      IACC: begin
        if (iREN) begin
          ram_ren  = 1'b1;
          ram_addr = iaddr;
          if (ram_ready) begin
            iwait = 1'b0;
            iload = ram_rdata;
          end else if (wd_fire) begin
            iwait = 1'b0;
            iload = BAD;
          end
        end
      end
      DACC: begin
        if (dreq) begin
          ram_wen   = d_is_wr;
          ram_ren   = dREN & ~d_is_wr;
          ram_addr  = daddr;
          ram_wdata = dstore;
          if (ram_ready) begin
            dwait = 1'b0;
            dload = d_is_wr ? '0 : ram_rdata;
          end else if (wd_fire) begin
            dwait = 1'b0;
            dload = BAD;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      istarve <= '0;
      wcnt    <= '0;
      wdog    <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wdog <= '0;
          wcnt <= '0;
          if (dreq && ((istarve < IS_MAX) || !iREN)) begin
            state <= DACC;
            if (iREN && (istarve != IS_MAX))
              istarve <= istarve + IS_W'(1);
          end else if (iREN) begin
            state   <= IACC;
            istarve <= '0;
          end
        end
        IACC: begin
          if (!iREN) begin
            state <= IDLE;
            wdog  <= '0;
          end else if (ram_ready) begin
            state <= IDLE;
            wdog  <= '0;
          end else if (wd_fire) begin
            err   <= 1'b1;
            state <= IDLE;
            wdog  <= '0;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        DACC: begin
          if (!dreq) begin
            state <= IDLE;
            wcnt  <= '0;
            wdog  <= '0;
          end else if (ram_ready) begin
            wdog <= '0;
            if (wcnt == WC_LAST) begin
              wcnt  <= '0;
              state <= IDLE;
            end else begin
              wcnt <= wcnt + WC_W'(1);
            end
          end else if (wd_fire) begin
            err   <= 1'b1;
            state <= IDLE;
            wcnt  <= '0;
            wdog  <= '0;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
